eq_pipe_matcher: RTL

- Parametrised, pipelined successor to the fixed 4-bit LUT-chain equality comparator.
- Compares a streaming WIDTH-bit input word against a loadable pattern with per-bit don't-care mask and optional inverted (not-equal) sense.
- The compare chain is split into CHUNK-bit pipeline stages, one LUT-level chain per stage, so timing holds at any width.
- Counts matches with a saturating counter. Used as a packet-header/keyword detector in iCE40 designs.

---
 rtl/eq_pipe_matcher.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/eq_pipe_matcher.sv
// eq_pipe_matcher
//   Pipelined masked equality detector. Each streaming WIDTH-bit word is
//   compared against a loadable pattern, with a per-bit compare mask and an
//   optional inverted (mismatch) sense. The compare is split into CHUNK-bit
//   stages (S = ceil(WIDTH/CHUNK)) so each stage is one short LUT chain.
//   Matching output events are counted by a saturating counter.
//
// Ports
//   CLK        clock, rising edge
//   RESET      synchronous active-high reset (overrides everything)
//   CE         clock enable for pipeline and counter increment
//   LOAD       capture PAT/MASK/INVERT and flush the pipeline
//   PAT        pattern word
//   MASK       per-bit compare enable (1 = compare, 0 = don't care)
//   INVERT     1 = report mismatch instead of match
//   COUNT_CLR  clear the match counter (acts regardless of CE)
//   I_VALID    I carries a word this cycle
//   I          data word
//   O_VALID    result valid (registered)
//   O          result, forced 0 when O_VALID is 0 (registered)
//   COUNT      saturating count of O_VALID && O events
//   SAT        COUNT is all ones (registered)
module eq_pipe_matcher #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHUNK     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic                 LOAD,
  input  logic [WIDTH-1:0]     PAT,
  input  logic [WIDTH-1:0]     MASK,
  input  logic                 INVERT,
  input  logic                 COUNT_CLR,
  input  logic                 I_VALID,
  input  logic [WIDTH-1:0]     I,
  output logic                 O_VALID,
  output logic                 O,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic                 SAT
);

  localparam int unsigned S = (WIDTH + CHUNK - 1) / CHUNK;

  // Bit-select for stage k; the upper bound is clipped by WIDTH so a
  // partial last stage only covers the remaining bits.
  function automatic logic [WIDTH-1:0] stage_sel(input int unsigned k);
    logic [WIDTH-1:0] sel;
    sel = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if ((b >= k * CHUNK) && (b < (k + 1) * CHUNK)) begin
        sel[b] = 1'b1;
      end
    end
    return sel;
  endfunction

  // Compare of stage k's chunk only; bits outside the chunk are forced to
  // "equal" and fold away as constants.
  function automatic logic chunk_eq(input int unsigned k,
                                    input logic [WIDTH-1:0] word,
                                    input logic [WIDTH-1:0] pat,
                                    input logic [WIDTH-1:0] mask);
    return &(~(mask & stage_sel(k)) | ~(word ^ pat));
  endfunction

  // Configuration
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             invert_q, invert_d;

  // Inputs to the final (output) stage
  logic             fin_eq;
  logic             fin_valid;
  logic [WIDTH-1:0] fin_data;

  // Output stage and counter
  logic                 o_q, o_d;
  logic                 o_valid_q, o_valid_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 sat_q, sat_d;

  always_comb begin
    pat_d    = pat_q;
    mask_d   = mask_q;
    invert_d = invert_q;
    if (LOAD) begin
      pat_d    = PAT;
      mask_d   = MASK;
      invert_d = INVERT;
    end
  end

  // Stages 0..S-2 carry a running eq flag, valid and the word; the last
  // stage is folded into the output register so its compare, invert and
  // valid gating land directly in O/O_VALID.
  generate
    if (S > 1) begin : g_pipe
      logic [S-2:0]     eq_q, eq_d;
      logic [S-2:0]     valid_q, valid_d;
      logic [WIDTH-1:0] data_q [S-1];
      logic [WIDTH-1:0] data_d [S-1];

      always_comb begin
        eq_d    = eq_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (LOAD) begin
          eq_d    = '0;
          valid_d = '0;
        end else if (CE) begin
          eq_d[0]    = chunk_eq(0, I, pat_q, mask_q);
          valid_d[0] = I_VALID;
          data_d[0]  = I;
          for (int unsigned k = 1; k < S - 1; k++) begin
            eq_d[k]    = eq_q[k-1] & chunk_eq(k, data_q[k-1], pat_q, mask_q);
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          eq_q    <= '0;
          valid_q <= '0;
        end else begin
          eq_q    <= eq_d;
          valid_q <= valid_d;
        end
      end

      // Data carry needs no reset: it is only observed through valid bits.
      always_ff @(posedge CLK) begin
        data_q <= data_d;
      end

      assign fin_eq    = eq_q[S-2];
      assign fin_valid = valid_q[S-2];
      assign fin_data  = data_q[S-2];
    end else begin : g_single
      assign fin_eq    = 1'b1;
      assign fin_valid = I_VALID;
      assign fin_data  = I;
    end
  endgenerate

  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    if (LOAD) begin
      o_d       = 1'b0;
      o_valid_d = 1'b0;
    end else if (CE) begin
      o_valid_d = fin_valid;
      o_d       = fin_valid &
                  ((fin_eq & chunk_eq(S - 1, fin_data, pat_q, mask_q)) ^ invert_q);
    end
  end

  // Counts on the values being registered this edge, so an event is
  // counted exactly once even though O holds while CE is low.
  always_comb begin
    count_d = count_q;
    if (COUNT_CLR) begin
      count_d = '0;
    end else if (CE && o_valid_d && o_d && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
    sat_d = &count_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pat_q     <= '0;
      mask_q    <= '1;
      invert_q  <= 1'b0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      invert_q  <= invert_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  assign O       = o_q;
  assign O_VALID = o_valid_q;
  assign COUNT   = count_q;
  assign SAT     = sat_q;

endmodule
